// File: rtl/pool1_channel_sequencer.sv
// Pool1 channel sequencer: streams each Conv1 channel into the pool
// input buffer, starts the pool engine, and tracks its completion.
//
// Ports:
//   clk, reset                  clock / async active-high reset
//   layer_start                 pulse, begins a layer when idle
//   data_in, data_valid_in      Conv1 output stream
//   data_ready_out              stream accepted (LOAD only)
//   data_in_from_previous       pool write data
//   ifm_address_write_previous  pool write address
//   ifm_enable_write_previous   pool write enable
//   start_from_previous         pool start pulse
//   end_from_next               downstream ready to pool
//   start_to_next               pool channel finished
//   ifm_enable_write_next       pool wrote one pooled word
//   next_ready                  downstream can take a channel
//   channel_idx, busy           status
//   layer_done                  pulse after the last channel
//   err_count, err_timeout      sticky error flags
module pool1_channel_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int IFM_SIZE       = 28,
    parameter int IFM_DEPTH      = 6,
    parameter int KERNAL_SIZE    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  layer_start,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    input  logic                                  data_valid_in,
    output logic                                  data_ready_out,
    output logic [DATA_WIDTH-1:0]                 data_in_from_previous,
    output logic [$clog2(IFM_SIZE*IFM_SIZE)-1:0]  ifm_address_write_previous,
    output logic                                  ifm_enable_write_previous,
    output logic                                  start_from_previous,
    output logic                                  end_from_next,
    input  logic                                  start_to_next,
    input  logic                                  ifm_enable_write_next,
    input  logic                                  next_ready,
    output logic [((IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1)-1:0] channel_idx,
    output logic                                  busy,
    output logic                                  layer_done,
    output logic                                  err_count,
    output logic                                  err_timeout
);

    localparam int IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / 2 + 1;
    localparam int NPIX   = IFM_SIZE * IFM_SIZE;
    localparam int OWORDS = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int CH_W   = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
    localparam int OCNT_W = $clog2(OWORDS) + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(NPIX - 1);
    localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(IFM_DEPTH - 1);
    localparam logic [OCNT_W:0]     OCNT_EXP  = (OCNT_W + 1)'(OWORDS);
    localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0]     addr, addr_n;
    logic [OCNT_W-1:0]     ocnt, ocnt_n;
    logic [TMR_W-1:0]      timer, timer_n;
    logic [OCNT_W:0]       ocnt_total;

    logic [DATA_WIDTH-1:0] wdata_n;
    logic [ADDR_W-1:0]     waddr_n;
    logic                  wen_n;
    logic                  start_n;
    logic                  end_n;
    logic [CH_W-1:0]       ch_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  errc_n;
    logic                  errt_n;

    // Only the ready signal is decoded straight from state.
    assign data_ready_out = (state == S_LOAD);

    // A pooled word arriving together with completion still counts.
    assign ocnt_total = {1'b0, ocnt} + (OCNT_W + 1)'(ifm_enable_write_next);

    always_comb begin
        state_n = state;
        addr_n  = addr;
        ocnt_n  = ocnt;
        timer_n = timer;
        wdata_n = data_in_from_previous;
        waddr_n = ifm_address_write_previous;
        wen_n   = 1'b0;
        start_n = 1'b0;
        end_n   = end_from_next;
        ch_n    = channel_idx;
        errc_n  = err_count;
        errt_n  = err_timeout;

        unique case (state)
            S_IDLE: begin
                if (layer_start) begin
                    state_n = S_LOAD;
                    ch_n    = '0;
                    addr_n  = '0;
                    errc_n  = 1'b0;
                    errt_n  = 1'b0;
                end
            end
            S_LOAD: begin
                if (data_valid_in) begin
                    wdata_n = data_in;
                    waddr_n = addr;
                    wen_n   = 1'b1;
                    if (addr == ADDR_LAST) begin
                        addr_n  = '0;
                        state_n = S_START;
                    end else begin
                        addr_n = addr + 1'b1;
                    end
                end
            end
            S_START: begin
                // Hold here until downstream can take a channel.
                if (next_ready) begin
                    start_n = 1'b1;
                    end_n   = 1'b1;
                    ocnt_n  = '0;
                    timer_n = '0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                timer_n = timer + 1'b1;
                if (ifm_enable_write_next && (ocnt != '1)) begin
                    ocnt_n = ocnt + 1'b1;
                end
                // Completion takes priority over a same-cycle timeout.
                if (start_to_next) begin
                    if (ocnt_total != OCNT_EXP) begin
                        errc_n = 1'b1;
                    end
                    end_n = 1'b0;
                    if (channel_idx == CH_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        ch_n    = channel_idx + 1'b1;
                        state_n = S_LOAD;
                    end
                end else if (timer == TMR_LAST) begin
                    errt_n  = 1'b1;
                    end_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            S_DONE: begin
                end_n   = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they
        // line up with the state they describe.
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= S_IDLE;
            addr                       <= '0;
            ocnt                       <= '0;
            timer                      <= '0;
            data_in_from_previous      <= '0;
            ifm_address_write_previous <= '0;
            ifm_enable_write_previous  <= 1'b0;
            start_from_previous        <= 1'b0;
            end_from_next              <= 1'b0;
            channel_idx                <= '0;
            busy                       <= 1'b0;
            layer_done                 <= 1'b0;
            err_count                  <= 1'b0;
            err_timeout                <= 1'b0;
        end else begin
            state                      <= state_n;
            addr                       <= addr_n;
            ocnt                       <= ocnt_n;
            timer                      <= timer_n;
            data_in_from_previous      <= wdata_n;
            ifm_address_write_previous <= waddr_n;
            ifm_enable_write_previous  <= wen_n;
            start_from_previous        <= start_n;
            end_from_next              <= end_n;
            channel_idx                <= ch_n;
            busy                       <= busy_n;
            layer_done                 <= done_n;
            err_count                  <= errc_n;
            err_timeout                <= errt_n;
        end
    end

endmodule

// File: tb/tb_pool1_channel_sequencer.sv
// Bench for pool1_channel_sequencer: directed layers with a write
// scoreboard and a small pool-engine model driven from tasks.
module tb_pool1_channel_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        layer_start;
    logic [31:0] data_in;
    logic        data_valid_in;
    logic        data_ready_out;
    logic [31:0] data_in_from_previous;
    logic [9:0]  ifm_address_write_previous;
    logic        ifm_enable_write_previous;
    logic        start_from_previous;
    logic        end_from_next;
    logic        start_to_next;
    logic        ifm_enable_write_next;
    logic        next_ready;
    logic [2:0]  channel_idx;
    logic        busy;
    logic        layer_done;
    logic        err_count;
    logic        err_timeout;

    always #5 clk = ~clk;

    pool1_channel_sequencer dut (
        .clk                        (clk),
        .reset                      (reset),
        .layer_start                (layer_start),
        .data_in                    (data_in),
        .data_valid_in              (data_valid_in),
        .data_ready_out             (data_ready_out),
        .data_in_from_previous      (data_in_from_previous),
        .ifm_address_write_previous (ifm_address_write_previous),
        .ifm_enable_write_previous  (ifm_enable_write_previous),
        .start_from_previous        (start_from_previous),
        .end_from_next              (end_from_next),
        .start_to_next              (start_to_next),
        .ifm_enable_write_next      (ifm_enable_write_next),
        .next_ready                 (next_ready),
        .channel_idx                (channel_idx),
        .busy                       (busy),
        .layer_done                 (layer_done),
        .err_count                  (err_count),
        .err_timeout                (err_timeout)
    );

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  failures = 0;
    int  starts = 0;
    int  dones = 0;

    // Monitor: every pool write must match the next expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifm_enable_write_previous) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected actual addr=%0d data=%h required none",
                             ifm_address_write_previous, data_in_from_previous);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (ifm_address_write_previous !== mon_e.a ||
                        data_in_from_previous !== mon_e.d) begin
                        failures++;
                        $display("FAIL wr_match actual addr=%0d data=%h required addr=%0d data=%h",
                                 ifm_address_write_previous, data_in_from_previous,
                                 mon_e.a, mon_e.d);
                    end
                end
            end
            if (start_from_previous) starts++;
            if (layer_done) dones++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_layer_start();
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
    endtask

    // Pattern 2-valid/1-idle when gaps is set.
    task automatic load_channel(input int ch, input int nwords, input bit gaps);
        logic [31:0] d;
        for (int i = 0; i < nwords; i++) begin
            if (gaps && i > 0 && (i % 2 == 0)) begin
                @(negedge clk);
                data_valid_in = 1'b0;
                data_in = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (i == 0) chk("ready_in_load", 32'(data_ready_out), 1);
            d = {8'hA5, 8'(ch), 16'(i)};
            data_valid_in = 1'b1;
            data_in = d;
            exp_q.push_back('{a: 10'(i), d: d});
        end
        @(negedge clk);
        data_valid_in = 1'b0;
        data_in = 32'h0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start_from_previous && n < 2000);
        chk("start_seen", 32'(start_from_previous), 1);
    endtask

    // Called on the cycle the start pulse is visible.
    task automatic run_pool(input int nw, input bit coincide);
        int sep;
        chk("end_in_run", 32'(end_from_next), 1);
        sep = coincide ? nw - 1 : nw;
        for (int i = 0; i < sep; i++) begin
            @(negedge clk);
            if (i == 0) chk("start_one_cycle", 32'(start_from_previous), 0);
            ifm_enable_write_next = 1'b1;
        end
        @(negedge clk);
        ifm_enable_write_next = coincide;
        start_to_next = 1'b1;
        @(negedge clk);
        ifm_enable_write_next = 1'b0;
        start_to_next = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        int s0;
        int d0;

        layer_start = 1'b0;
        data_in = '0;
        data_valid_in = 1'b0;
        start_to_next = 1'b0;
        ifm_enable_write_next = 1'b0;
        next_ready = 1'b1;

        // Reset and idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_ready", 32'(data_ready_out), 0);
        chk("rst_wdata", data_in_from_previous, 0);
        chk("rst_waddr", 32'(ifm_address_write_previous), 0);
        chk("rst_wen", 32'(ifm_enable_write_previous), 0);
        chk("rst_start", 32'(start_from_previous), 0);
        chk("rst_end", 32'(end_from_next), 0);
        chk("rst_ch", 32'(channel_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(layer_done), 0);
        chk("rst_errc", 32'(err_count), 0);
        chk("rst_errt", 32'(err_timeout), 0);

        // Layer A: back-to-back channel, stalled start, short count
        pulse_layer_start();
        chk("a_busy", 32'(busy), 1);
        chk("a_ch0", 32'(channel_idx), 0);
        load_channel(0, 784, 1'b0);
        wait_start(n);
        chk("start_latency", n, 1);
        run_pool(196, 1'b0);
        chk("a_ch_after0", 32'(channel_idx), 1);
        chk("a_errc0", 32'(err_count), 0);

        next_ready = 1'b0;
        load_channel(1, 784, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (start_from_previous || end_from_next || data_ready_out) bad++;
            layer_start = (i == 10);
            data_valid_in = 1'b1;
            data_in = 32'hDEAD_BEEF;
        end
        chk("hold_no_start", bad, 0);
        data_valid_in = 1'b0;
        layer_start = 1'b0;
        next_ready = 1'b1;
        wait_start(n);
        chk("start_after_ready", n, 1);
        chk("hold_ch_kept", 32'(channel_idx), 1);
        run_pool(195, 1'b0);
        chk("errc_short", 32'(err_count), 1);
        chk("a_ch_after1", 32'(channel_idx), 2);

        for (int ch = 2; ch < 6; ch++) begin
            load_channel(ch, 784, 1'b0);
            wait_start(n);
            run_pool(196, 1'b0);
        end
        chk("a_done_pulse", 32'(layer_done), 1);
        @(negedge clk);
        chk("a_done_low", 32'(layer_done), 0);
        chk("a_idle", 32'(busy), 0);
        chk("a_dones", dones, 1);
        chk("errc_sticky", 32'(err_count), 1);

        // Layer B: valid gaps, one completion with a same-cycle write
        s0 = starts;
        d0 = dones;
        pulse_layer_start();
        chk("b_errc_clr", 32'(err_count), 0);
        chk("b_ch0", 32'(channel_idx), 0);
        for (int ch = 0; ch < 6; ch++) begin
            load_channel(ch, 784, 1'b1);
            wait_start(n);
            if (ch == 5) chk("b_no_early_done", dones - d0, 0);
            run_pool(196, ch == 3);
        end
        @(negedge clk);
        chk("b_starts", starts - s0, 6);
        chk("b_dones", dones - d0, 1);
        chk("b_errc", 32'(err_count), 0);
        chk("b_idle", 32'(busy), 0);

        // Layer C: pool never completes
        pulse_layer_start();
        load_channel(0, 784, 1'b0);
        wait_start(n);
        d0 = dones;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 5000);
        chk("timeout_cycles", n, 4096);
        chk("errt_set", 32'(err_timeout), 1);
        chk("c_end_low", 32'(end_from_next), 0);
        chk("c_no_done", dones - d0, 0);
        chk("c_errc", 32'(err_count), 0);

        // Reset in the middle of a load
        pulse_layer_start();
        chk("errt_clr", 32'(err_timeout), 0);
        load_channel(0, 301, 1'b0);
        chk("mid_addr", 32'(ifm_address_write_previous), 300);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_waddr", 32'(ifm_address_write_previous), 0);
        chk("arst_wdata", data_in_from_previous, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(data_ready_out), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        pulse_layer_start();
        chk("restart_ch", 32'(channel_idx), 0);
        load_channel(0, 784, 1'b0);
        wait_start(n);
        chk("restart_latency", n, 1);
        run_pool(196, 1'b0);
        chk("restart_ch1", 32'(channel_idx), 1);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
